// File: rtl/bb8051_fetch_pkg.sv
// Shared constants for the BB8051 fetch stage: instruction length codes and
// prefetch buffer geometry.
package bb8051_fetch_pkg;

  localparam logic [1:0] BB8051_LEN_1 = 2'd1;
  localparam logic [1:0] BB8051_LEN_2 = 2'd2;
  localparam logic [1:0] BB8051_LEN_3 = 2'd3;

  localparam int BB8051_FETCH_BUF_DEPTH = 4;
  localparam int BB8051_FETCH_PTR_W     = $clog2(BB8051_FETCH_BUF_DEPTH);
  localparam int BB8051_FETCH_CNT_W     = $clog2(BB8051_FETCH_BUF_DEPTH + 1);

endpackage

// File: rtl/bb8051_op_len.sv
// Combinational 8051 instruction length lookup (1..3 bytes) from the opcode
// byte; also used by the interrupt logic.
module bb8051_op_len
  import bb8051_fetch_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len
);

  always_comb begin
    // NOTE: default first so every path assigns len and no latch is inferred.
    len = BB8051_LEN_1;
    casez (opcode)
      8'h02, 8'h10, 8'h12, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63,
      8'h75, 8'h85, 8'h90, 8'b101101??, 8'b10111???, 8'hD5:
        len = BB8051_LEN_3;
      // AJMP / ACALL page forms
      8'b???00001, 8'b???10001,
      8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35, 8'h40, 8'h42,
      8'h44, 8'h45, 8'h50, 8'h52, 8'h54, 8'h55, 8'h60, 8'h62,
      8'h64, 8'h65, 8'h70, 8'h72, 8'h74, 8'h76, 8'h77, 8'b01111???,
      8'h80, 8'h82, 8'h86, 8'h87, 8'b10001???, 8'h92, 8'h94, 8'h95,
      8'hA0, 8'hA2, 8'hA6, 8'hA7, 8'b10101???, 8'hB0, 8'hB2, 8'hC0,
      8'hC2, 8'hC5, 8'hD0, 8'hD2, 8'b11011???, 8'hE5, 8'hF5:
        len = BB8051_LEN_2;
      default:
        len = BB8051_LEN_1;
    endcase
  end

endmodule

// File: rtl/bb8051_fetch.sv
// BB8051 instruction fetch: 4-byte prefetch buffer, length decode, issue to the
// decoder with stall hold and PC redirect. Optional BB8051_FETCH_STALL_CNT_EN adds stall_cnt.
module bb8051_fetch
  import bb8051_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] rom_addr,
  output logic        rom_rd,
  input  logic [7:0]  rom_data,
  input  logic        pc_wr,
  input  logic [15:0] pc_in,
  input  logic        decoder_wait,
  output logic [7:0]  op1_out,
  output logic [7:0]  op2_out,
  output logic [7:0]  op3_out,
  output logic [1:0]  op_len,
  output logic [15:0] op_pc,
  output logic        op_valid
`ifdef BB8051_FETCH_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int PW = BB8051_FETCH_PTR_W;
  localparam int CW = BB8051_FETCH_CNT_W;

  logic [7:0]    buf_q [BB8051_FETCH_BUF_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          inflight;
  logic          discard;
  logic [15:0]   head_pc;

  logic [1:0]    head_len;
  logic [PW-1:0] ptr1, ptr2;
  logic [CW:0]   credit_used;
  logic          push, issue;
  logic [1:0]    pop_n;

  bb8051_op_len u_op_len (
    .opcode (buf_q[head]),
    .len    (head_len)
  );

  assign ptr1        = head + PW'(1);
  assign ptr2        = head + PW'(2);
  assign credit_used = {1'b0, count} + (CW+1)'(inflight);
  assign rom_rd      = rst && (credit_used < (CW+1)'(BB8051_FETCH_BUF_DEPTH));
  assign push        = inflight && !discard;
  assign issue       = (!op_valid || !decoder_wait) && (count >= CW'(head_len));
  assign pop_n       = issue ? head_len : 2'd0;

  // NOTE: the byte store has no reset; head/tail/count alone say which entries are live.
  always_ff @(posedge clk) begin
    if (push && !pc_wr)
      buf_q[tail] <= rom_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr <= RESET_PC;
      head_pc  <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= 1'b0;
      discard  <= 1'b0;
      op1_out  <= 8'h00;
      op2_out  <= 8'h00;
      op3_out  <= 8'h00;
      op_len   <= BB8051_LEN_1;
      op_pc    <= 16'h0000;
      op_valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
      inflight <= rom_rd;
      if (pc_wr) begin
        // A read issued this cycle returns stale data next cycle; drop it.
        discard  <= 1'b1;
        rom_addr <= pc_in;
        head_pc  <= pc_in;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        op_valid <= 1'b0;
      end else begin
        discard <= 1'b0;
        if (rom_rd)
          rom_addr <= rom_addr + 16'd1;
        if (push)
          tail <= tail + PW'(1);
        head  <= head + PW'(pop_n);
        count <= count - CW'(pop_n) + CW'(push);
        if (issue) begin
          op1_out  <= buf_q[head];
          op2_out  <= (head_len >= BB8051_LEN_2) ? buf_q[ptr1] : 8'h00;
          op3_out  <= (head_len == BB8051_LEN_3) ? buf_q[ptr2] : 8'h00;
          op_len   <= head_len;
          op_pc    <= head_pc;
          head_pc  <= head_pc + 16'(head_len);
          op_valid <= 1'b1;
        end else if (op_valid && !decoder_wait) begin
          op_valid <= 1'b0;
        end
      end
    end
  end

`ifdef BB8051_FETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= 16'h0000;
    else if (!op_valid && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
